// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, states, mux selects, alu_op codes.
// TRAP state exists only when ILLEGAL_TRAP_EN is defined.
package mc_control_fsm_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
`ifdef ILLEGAL_TRAP_EN
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
`else
        S_BEQ      = 4'd10
`endif
    } state_t;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // fetch: strobes that only fire once memory delivers the instruction
    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       fetch;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       illegal;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_word_t;

    function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control/status bundle between the control FSM (master) and the datapath (slave).
// Carries the opcode, ALU/memory status and all datapath selects and strobes.
interface mc_control_fsm_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] imm_src;
    logic       illegal_instr;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, reg_write, imm_src, illegal_instr
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, reg_write, imm_src, illegal_instr
    );
endinterface

// File: rtl/mc_output_decode.sv
// Moore output decode: registered state -> control word, purely combinational.
// Latency: 0 cycles. Backpressure: none; memory qualification is applied by the caller.
// ILLEGAL_TRAP_EN adds the TRAP state decode.
module mc_output_decode
    import mc_control_fsm_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] state,
    output ctrl_word_t         cw
);

    always_comb begin
        cw = '0;
        case (state)
            STATE_W'(S_FETCH): begin
                cw.fetch      = 1'b1;
                cw.alu_src_b  = SRCB_FOUR;
                cw.result_src = RES_ALU;
            end
            STATE_W'(S_DECODE): begin
                cw.alu_src_a = SRCA_OLDPC;
                cw.alu_src_b = SRCB_IMM;
            end
            STATE_W'(S_MEMADR): begin
                cw.alu_src_a = SRCA_RS1;
                cw.alu_src_b = SRCB_IMM;
            end
            STATE_W'(S_MEMREAD): begin
                cw.adr_src    = 1'b1;
                cw.result_src = RES_ALUOUT;
            end
            STATE_W'(S_MEMWB): begin
                cw.result_src = RES_RDATA;
                cw.reg_write  = 1'b1;
            end
            STATE_W'(S_MEMWRITE): begin
                cw.adr_src   = 1'b1;
                cw.mem_write = 1'b1;
            end
            STATE_W'(S_EXECR): begin
                cw.alu_src_a = SRCA_RS1;
                cw.alu_src_b = SRCB_RS2;
                cw.alu_op    = ALU_FUNCT;
            end
            STATE_W'(S_EXECI): begin
                cw.alu_src_a = SRCA_RS1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALU_FUNCT;
            end
            STATE_W'(S_ALUWB): begin
                cw.result_src = RES_ALUOUT;
                cw.reg_write  = 1'b1;
            end
            STATE_W'(S_JAL): begin
                cw.alu_src_a  = SRCA_OLDPC;
                cw.alu_src_b  = SRCB_FOUR;
                cw.alu_op     = ALU_ADD;
                cw.result_src = RES_ALUOUT;
                cw.pc_update  = 1'b1;
            end
            STATE_W'(S_BEQ): begin
                cw.alu_src_a  = SRCA_RS1;
                cw.alu_src_b  = SRCB_RS2;
                cw.alu_op     = ALU_SUB;
                cw.result_src = RES_ALUOUT;
                cw.branch     = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            STATE_W'(S_TRAP): cw.illegal = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I main control FSM: sequences fetch/decode/execute/writeback, drives datapath controls.
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles; each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds one.
// Backpressure: stalls on mem_ready. ILLEGAL_TRAP_EN: unsupported opcodes trap until reset.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mc_control_fsm_if.master  bus
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    ctrl_word_t         cw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= STATE_W'(S_FETCH);
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = STATE_W'(S_FETCH);
        case (state_q)
            STATE_W'(S_FETCH):
                state_d = bus.mem_ready ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
            STATE_W'(S_DECODE): begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = STATE_W'(S_MEMADR);
                    OP_R:         state_d = STATE_W'(S_EXECR);
                    OP_I:         state_d = STATE_W'(S_EXECI);
                    OP_JAL:       state_d = STATE_W'(S_JAL);
                    OP_BEQ:       state_d = STATE_W'(S_BEQ);
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = STATE_W'(S_TRAP);
`else
                    default:      state_d = STATE_W'(S_FETCH);
`endif
                endcase
            end
            STATE_W'(S_MEMADR):
                state_d = (bus.opcode == OP_LW) ? STATE_W'(S_MEMREAD) : STATE_W'(S_MEMWRITE);
            STATE_W'(S_MEMREAD):
                state_d = bus.mem_ready ? STATE_W'(S_MEMWB) : STATE_W'(S_MEMREAD);
            STATE_W'(S_MEMWRITE):
                state_d = bus.mem_ready ? STATE_W'(S_FETCH) : STATE_W'(S_MEMWRITE);
            STATE_W'(S_EXECR), STATE_W'(S_EXECI), STATE_W'(S_JAL):
                state_d = STATE_W'(S_ALUWB);
`ifdef ILLEGAL_TRAP_EN
            STATE_W'(S_TRAP):
                state_d = state_q;
`endif
            default:
                state_d = STATE_W'(S_FETCH);
        endcase
    end

    mc_output_decode #(.STATE_W(STATE_W)) u_decode (
        .state (state_q),
        .cw    (cw)
    );

    // Strobes are gated by rst_n so they drop the moment reset asserts.
    assign bus.pc_write      = rst_n & ((cw.fetch & bus.mem_ready) | cw.pc_update | (cw.branch & bus.zero));
    assign bus.ir_write      = rst_n & cw.fetch & bus.mem_ready;
    assign bus.mem_write     = rst_n & cw.mem_write;
    assign bus.reg_write     = rst_n & cw.reg_write;
    assign bus.adr_src       = cw.adr_src;
    assign bus.result_src    = cw.result_src;
    assign bus.alu_src_a     = cw.alu_src_a;
    assign bus.alu_src_b     = cw.alu_src_b;
    assign bus.alu_op        = cw.alu_op;
    assign bus.illegal_instr = cw.illegal;
    assign bus.imm_src       = imm_src_of(bus.opcode);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: a per-instruction step-list model predicts every cycle's outputs.
module tb_mc_control_fsm;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mc_control_fsm_if bus();

    mc_control_fsm #(.STATE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5;
    localparam int P_ER = 6, P_EI = 7, P_AWB = 8, P_J = 9, P_B = 10, P_T = 11;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       illegal;
    } outs_t;

    int seq[$];

    // Expected outputs of each instruction step, straight from the state table.
    function automatic outs_t expect_outs(int p, bit rdy, bit z);
        outs_t o = '0;
        case (p)
            P_F:   begin o.alu_src_b = 2'b10; o.result_src = 2'b10; o.ir_write = rdy; o.pc_write = rdy; end
            P_D:   begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; end
            P_MA:  begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
            P_MR:  o.adr_src = 1'b1;
            P_MWB: begin o.result_src = 2'b01; o.reg_write = 1'b1; end
            P_MW:  begin o.adr_src = 1'b1; o.mem_write = 1'b1; end
            P_ER:  begin o.alu_src_a = 2'b10; o.alu_op = 2'b10; end
            P_EI:  begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.alu_op = 2'b10; end
            P_AWB: o.reg_write = 1'b1;
            P_J:   begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.pc_write = 1'b1; end
            P_B:   begin o.alu_src_a = 2'b10; o.alu_op = 2'b01; o.pc_write = z; end
            P_T:   o.illegal = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic outs_t reset_outs(bit rdy);
        outs_t o = expect_outs(P_F, rdy, 1'b0);
        o.pc_write = 1'b0;
        o.ir_write = 1'b0;
        return o;
    endfunction

    function automatic int exp_imm(logic [6:0] op);
        case (op)
            7'b0100011: return 1;
            7'b1100011: return 2;
            7'b1101111: return 3;
            default:    return 0;
        endcase
    endfunction

    function automatic int base_latency(logic [6:0] op);
        case (op)
            7'b0000011: return 5;
            7'b0100011: return 4;
            7'b0110011: return 4;
            7'b0010011: return 4;
            7'b1101111: return 4;
            7'b1100011: return 3;
`ifdef ILLEGAL_TRAP_EN
            default:    return 3;
`else
            default:    return 2;
`endif
        endcase
    endfunction

    function automatic void build_seq(logic [6:0] op);
        seq = '{P_F, P_D};
        case (op)
            7'b0000011: begin seq.push_back(P_MA); seq.push_back(P_MR); seq.push_back(P_MWB); end
            7'b0100011: begin seq.push_back(P_MA); seq.push_back(P_MW); end
            7'b0110011: begin seq.push_back(P_ER); seq.push_back(P_AWB); end
            7'b0010011: begin seq.push_back(P_EI); seq.push_back(P_AWB); end
            7'b1101111: begin seq.push_back(P_J);  seq.push_back(P_AWB); end
            7'b1100011: seq.push_back(P_B);
            default: begin
`ifdef ILLEGAL_TRAP_EN
                seq.push_back(P_T);
`endif
            end
        endcase
    endfunction

    function automatic bit waitable(int p);
        return (p == P_F) || (p == P_MR) || (p == P_MW);
    endfunction

    function automatic int pick_stall(int rmode);
        if (rmode == 2) return 3;
        if (rmode == 1) return $urandom_range(0, 2);
        return 0;
    endfunction

    function automatic outs_t dut_outs();
        outs_t o;
        o.pc_write   = bus.pc_write;
        o.adr_src    = bus.adr_src;
        o.mem_write  = bus.mem_write;
        o.ir_write   = bus.ir_write;
        o.result_src = bus.result_src;
        o.alu_src_a  = bus.alu_src_a;
        o.alu_src_b  = bus.alu_src_b;
        o.alu_op     = bus.alu_op;
        o.reg_write  = bus.reg_write;
        o.illegal    = bus.illegal_instr;
        return o;
    endfunction

    task automatic check_outs(string name, outs_t exp);
        outs_t got = dut_outs();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s opcode=%b: got %h required %h", name, bus.opcode, got, exp);
        end
    endtask

    task automatic check_int(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    // Reset asserted mid-cycle; released just after a rising edge so FETCH is seen for a full cycle next.
    task automatic pulse_reset(bit rdy);
        rst_n = 1'b0;
        #1;
        check_outs("reset_mid_instr", reset_outs(rdy));
        check_int("mem_write_on_reset", int'(bus.mem_write), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input logic [6:0] op, input int rmode, input int zmode,
                             input bit rst_in_mw, output int cycles);
        int idx;
        int stall;
        int p;
        bit rdy;
        bit z;
        build_seq(op);
        check_int("model_latency", seq.size(), base_latency(op));
        idx    = 0;
        cycles = 0;
        stall  = pick_stall(rmode);
        while (idx < seq.size()) begin
            @(negedge clk);
            p = seq[idx];
            if (cycles == 0) bus.opcode = op;
            rdy = waitable(p) ? (stall == 0) : 1'($urandom_range(0, 1));
            z   = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            bus.mem_ready = rdy;
            bus.zero      = z;
            #1;
            check_outs($sformatf("step%0d", p), expect_outs(p, rdy, z));
            check_int("imm_src", int'(bus.imm_src), exp_imm(op));
            cycles++;
            if (p == P_T) begin
                repeat (3) begin
                    @(negedge clk);
                    rdy = 1'($urandom_range(0, 1));
                    bus.mem_ready = rdy;
                    #1;
                    check_outs("trap_hold", expect_outs(P_T, rdy, 1'b0));
                end
                pulse_reset(rdy);
                return;
            end
            if (rst_in_mw && p == P_MW) begin
                pulse_reset(rdy);
                return;
            end
            if (waitable(p) && !rdy) begin
                stall--;
            end else begin
                idx++;
                if (idx < seq.size() && waitable(seq[idx])) stall = pick_stall(rmode);
            end
        end
    endtask

    initial begin
        int cyc;
        logic [6:0] op;
        rst_n         = 1'b0;
        bus.opcode    = 7'b0110011;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_outs("reset_state", reset_outs(1'b1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(7'b0110011, 0, 0, 1'b0, cyc); check_int("latency_r", cyc, 4);
        run_instr(7'b0000011, 0, 0, 1'b0, cyc); check_int("latency_lw", cyc, 5);
        run_instr(7'b0100011, 0, 0, 1'b0, cyc); check_int("latency_sw", cyc, 4);
        run_instr(7'b1100011, 0, 1, 1'b0, cyc); check_int("latency_beq_taken", cyc, 3);
        run_instr(7'b1100011, 0, 0, 1'b0, cyc); check_int("latency_beq_not", cyc, 3);
        run_instr(7'b1101111, 0, 0, 1'b0, cyc); check_int("latency_jal", cyc, 4);
        run_instr(7'b0010011, 0, 0, 1'b0, cyc); check_int("latency_i", cyc, 4);
        run_instr(7'b0000011, 2, 0, 1'b0, cyc); check_int("latency_lw_wait", cyc, 11);
        run_instr(7'b0100011, 0, 0, 1'b1, cyc);
        run_instr(7'b1111111, 0, 0, 1'b0, cyc);
        run_instr(7'b0110011, 0, 0, 1'b0, cyc); check_int("latency_after_reset", cyc, 4);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 6))
                0: op = 7'b0000011;
                1: op = 7'b0100011;
                2: op = 7'b0110011;
                3: op = 7'b0010011;
                4: op = 7'b1101111;
                5: op = 7'b1100011;
                default: op = 7'($urandom);
            endcase
            run_instr(op, 1, 2, ($urandom_range(0, 19) == 0), cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
